// File: rtl/vga_gpu_pkg.sv
// vga_gpu_pkg: shared command encoding and widths for the VGA colour pipeline
package vga_gpu_pkg;
   localparam int COLOR_W   = 12;
   localparam int MAX_RECTS = 4;
   typedef enum logic [3:0] {
      OP_SET_BG      = 4'h1,
      OP_RECT_ORIGIN = 4'h2,
      OP_RECT_EXTENT = 4'h3,
      OP_RECT_COLOR  = 4'h4,
      OP_COMMIT      = 4'h5
   } opcode_t;
   localparam int OP_LSB  = 28;
   localparam int IDX_LSB = 26;
   localparam int FA_LSB  = 10;
   localparam int FB_LSB  = 0;
   localparam int FIELD_W = 10;
   localparam int EN_BIT  = 12;
endpackage

// File: rtl/rect_hit.sv
// rect_hit: inclusive unsigned point-in-rectangle test
module rect_hit #(
   parameter int COORD_W = 10
) (
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y1,
   input  logic               en,
   output logic               hit
);
   assign hit = en && x >= x0 && x <= x1 && y >= y0 && y <= y1;
endmodule

// File: rtl/pixel_color_source.sv
// pixel_color_source: double-buffered background/rectangle colour source, committed at frame start
module pixel_color_source
   import vga_gpu_pkg::*;
#(
   parameter int N_RECTS = 4,
   parameter int COORD_W = 10
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic [31:0]        i_instruction,
   input  logic               i_instruction_ready,
   input  logic [COORD_W-1:0] i_pixel_x,
   input  logic [COORD_W-1:0] i_pixel_y,
   output logic [COLOR_W-1:0] o_color,
   output logic               o_commit_pending,
   output logic               o_instr_dropped
);
   typedef struct packed {
      logic               en;
      logic [COLOR_W-1:0] color;
      logic [COORD_W-1:0] x0;
      logic [COORD_W-1:0] y0;
      logic [COORD_W-1:0] x1;
      logic [COORD_W-1:0] y1;
   } rect_t;
   rect_t              sh_rect [N_RECTS];
   rect_t              ac_rect [N_RECTS];
   logic [COLOR_W-1:0] sh_bg, ac_bg, pix_color;
   logic [N_RECTS-1:0] hit;
   logic [3:0]         op;
   logic [1:0]         idx;
   logic [FIELD_W-1:0] fa, fb;
   logic               prev_zero, at_zero, frame_start, accept, rect_ok, unused_bits;
   assign op          = i_instruction[OP_LSB +: 4];
   assign idx         = i_instruction[IDX_LSB +: 2];
   assign fa          = i_instruction[FA_LSB +: FIELD_W];
   assign fb          = i_instruction[FB_LSB +: FIELD_W];
   assign unused_bits = ^i_instruction[IDX_LSB-1:FA_LSB+FIELD_W];
   assign at_zero     = i_pixel_x == '0 && i_pixel_y == '0;
   assign frame_start = at_zero && !prev_zero;
   // while a commit waits for frame start the shadow copy is frozen
   assign accept      = i_instruction_ready && !o_commit_pending;
   assign rect_ok     = accept && int'(idx) < N_RECTS;
   for (genvar g = 0; g < N_RECTS; g++) begin : g_rect
      rect_hit #(.COORD_W(COORD_W)) u_hit (
         .x  (i_pixel_x),
         .y  (i_pixel_y),
         .x0 (ac_rect[g].x0),
         .y0 (ac_rect[g].y0),
         .x1 (ac_rect[g].x1),
         .y1 (ac_rect[g].y1),
         .en (ac_rect[g].en),
         .hit(hit[g])
      );
   end
   // scan from the top index down so the lowest hitting index wins
   always_comb begin
      pix_color = ac_bg;
      for (int i = N_RECTS - 1; i >= 0; i--)
         pix_color = hit[i] ? ac_rect[i].color : pix_color;
   end
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         o_color          <= '0;
         o_commit_pending <= 1'b0;
         o_instr_dropped  <= 1'b0;
         prev_zero        <= 1'b0;
         sh_bg            <= '0;
         ac_bg            <= '0;
         for (int i = 0; i < N_RECTS; i++) begin
            sh_rect[i] <= '0;
            ac_rect[i] <= '0;
         end
      end else begin
         o_color          <= pix_color;
         o_instr_dropped  <= i_instruction_ready && o_commit_pending;
         o_commit_pending <= o_commit_pending ? !frame_start : accept && op == OP_COMMIT;
         prev_zero        <= at_zero;
         if (accept && op == OP_SET_BG)
            sh_bg <= i_instruction[COLOR_W-1:0];
         if (rect_ok && op == OP_RECT_ORIGIN) begin
            sh_rect[idx].x0 <= COORD_W'(fa);
            sh_rect[idx].y0 <= COORD_W'(fb);
         end
         if (rect_ok && op == OP_RECT_EXTENT) begin
            sh_rect[idx].x1 <= COORD_W'(fa);
            sh_rect[idx].y1 <= COORD_W'(fb);
         end
         if (rect_ok && op == OP_RECT_COLOR) begin
            sh_rect[idx].en    <= i_instruction[EN_BIT];
            sh_rect[idx].color <= i_instruction[COLOR_W-1:0];
         end
         if (frame_start && o_commit_pending) begin
            ac_bg   <= sh_bg;
            ac_rect <= sh_rect;
         end
      end
   end
endmodule

// File: tb/tb_pixel_color_source.sv
// tb_pixel_color_source: directed vectors checked against a frame-level colour model every cycle
module tb_pixel_color_source;
   logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b0;
   logic [31:0] instr = '0;
   logic [9:0]  px = 10'd100, py = 10'd100;
   logic [11:0] color;
   logic        pend, drop;
   int          n_cmp = 0, n_bad = 0;
   always #5 clk = ~clk;
   pixel_color_source #(.N_RECTS(4), .COORD_W(10)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_instruction(instr), .i_instruction_ready(rdy),
      .i_pixel_x(px), .i_pixel_y(py), .o_color(color), .o_commit_pending(pend),
      .o_instr_dropped(drop)
   );
   int          s_bg, a_bg, op, ix;
   int          s_x0[4], s_y0[4], s_x1[4], s_y1[4], s_col[4];
   int          a_x0[4], a_y0[4], a_x1[4], a_y1[4], a_col[4];
   bit          s_en[4], a_en[4];
   bit          m_pend, m_prev00, armed, at00, fs, cmt;
   logic [11:0] e_color;
   logic        e_pend, e_drop;
   function automatic logic [11:0] model_color(int x, int y);
      for (int i = 0; i < 4; i++)
         if (a_en[i] && x >= a_x0[i] && x <= a_x1[i] && y >= a_y0[i] && y <= a_y1[i])
            return 12'(a_col[i]);
      return 12'(a_bg);
   endfunction
   always @(posedge clk) begin
      if (!rst_n) begin
         s_bg = 0; a_bg = 0; m_pend = 0; m_prev00 = 0;
         for (int i = 0; i < 4; i++) begin
            s_x0[i] = 0; s_y0[i] = 0; s_x1[i] = 0; s_y1[i] = 0; s_col[i] = 0; s_en[i] = 0;
            a_x0[i] = 0; a_y0[i] = 0; a_x1[i] = 0; a_y1[i] = 0; a_col[i] = 0; a_en[i] = 0;
         end
         e_color = 0; e_pend = 0; e_drop = 0;
      end else begin
         at00 = px == 0 && py == 0;
         fs = at00 && !m_prev00;
         m_prev00 = at00;
         e_color = model_color(px, py);
         e_drop = rdy && m_pend;
         cmt = 0;
         if (rdy && !m_pend) begin
            op = int'(instr[31:28]);
            ix = int'(instr[27:26]);
            case (op)
               1: s_bg = int'(instr[11:0]);
               2: begin s_x0[ix] = int'(instr[19:10]); s_y0[ix] = int'(instr[9:0]); end
               3: begin s_x1[ix] = int'(instr[19:10]); s_y1[ix] = int'(instr[9:0]); end
               4: begin s_en[ix] = instr[12]; s_col[ix] = int'(instr[11:0]); end
               5: cmt = 1;
               default: ;
            endcase
         end
         if (fs && m_pend) begin
            a_bg = s_bg; a_x0 = s_x0; a_y0 = s_y0; a_x1 = s_x1; a_y1 = s_y1;
            a_col = s_col; a_en = s_en; m_pend = 0;
         end else if (cmt) m_pend = 1;
         e_pend = m_pend;
      end
      armed = 1;
   end
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   always @(negedge clk) if (armed) begin
      chk("model_color", 32'(color), 32'(e_color));
      chk("model_pending", 32'(pend), 32'(e_pend));
      chk("model_dropped", 32'(drop), 32'(e_drop));
   end
   task automatic step();
      @(negedge clk);
   endtask
   task automatic send(logic [31:0] w);
      instr = w; rdy = 1'b1;
      step();
      rdy = 1'b0; instr = '0;
   endtask
   task automatic frame();
      px = 0; py = 0;
      step();
   endtask
   task automatic sample(int x, int y);
      px = 10'(x); py = 10'(y);
      step();
   endtask
   function automatic logic [31:0] w_bg(logic [11:0] c);
      return {4'h1, 16'h0, c};
   endfunction
   function automatic logic [31:0] w_xy(logic [3:0] o, logic [1:0] i, logic [9:0] a, logic [9:0] b);
      return {o, i, 6'h0, a, b};
   endfunction
   function automatic logic [31:0] w_col(logic [1:0] i, logic en, logic [11:0] c);
      return {4'h4, i, 13'h0, en, c};
   endfunction
   localparam logic [31:0] CMT = 32'h5000_0000;
   initial begin
      step(); step();
      chk("reset_color", 32'(color), 32'h000);
      chk("reset_pending", 32'(pend), 32'h0);
      rst_n = 1'b1;
      sample(5, 5);
      chk("after_reset_5_5", 32'(color), 32'h000);
      chk("after_reset_pending", 32'(pend), 32'h0);
      send(w_bg(12'h00F)); send(CMT);
      chk("commit_pending_set", 32'(pend), 32'h1);
      step();
      chk("commit_pending_hold", 32'(pend), 32'h1);
      frame();
      chk("commit_pending_clear", 32'(pend), 32'h0);
      sample(7, 3);
      chk("bg_00f", 32'(color), 32'h00F);
      send(w_xy(4'h2, 2'd0, 10'd10, 10'd10));
      send(w_xy(4'h3, 2'd0, 10'd20, 10'd20));
      send(w_col(2'd0, 1'b1, 12'hF00));
      send(CMT); frame();
      sample(10, 10); chk("rect0_10_10", 32'(color), 32'hF00);
      sample(20, 20); chk("rect0_20_20", 32'(color), 32'hF00);
      sample(9, 10);  chk("rect0_9_10", 32'(color), 32'h00F);
      sample(21, 20); chk("rect0_21_20", 32'(color), 32'h00F);
      send(w_xy(4'h2, 2'd1, 10'd12, 10'd12));
      send(w_xy(4'h3, 2'd1, 10'd30, 10'd30));
      send(w_col(2'd1, 1'b1, 12'h0F0));
      send(CMT); frame();
      sample(15, 15); chk("overlap_low_wins", 32'(color), 32'hF00);
      sample(25, 25); chk("rect1_only", 32'(color), 32'h0F0);
      send(w_col(2'd0, 1'b0, 12'hF00));
      send(CMT); frame();
      sample(15, 15); chk("rect0_disabled", 32'(color), 32'h0F0);
      send(w_bg(12'h123));
      sample(200, 200); chk("shadow_hidden", 32'(color), 32'h00F);
      send(CMT);
      send(w_bg(12'hFFF));
      chk("drop_pulse", 32'(drop), 32'h1);
      step();
      chk("drop_single", 32'(drop), 32'h0);
      frame();
      sample(400, 400); chk("dropped_bg_ignored", 32'(color), 32'h123);
      send(32'h7000_0ABC);
      chk("bad_op_no_drop", 32'(drop), 32'h0);
      send(32'h0000_0FFF);
      send(w_xy(4'h2, 2'd2, 10'd50, 10'd50));
      send(w_xy(4'h3, 2'd2, 10'd40, 10'd60));
      send(w_col(2'd2, 1'b1, 12'h0FF));
      send(w_xy(4'h2, 2'd3, 10'd60, 10'd60));
      send(w_xy(4'h3, 2'd3, 10'd70, 10'd55));
      send(w_col(2'd3, 1'b1, 12'hABC));
      send(CMT); frame();
      sample(45, 55); chk("inverted_x_45", 32'(color), 32'h123);
      sample(50, 55); chk("inverted_x_50", 32'(color), 32'h123);
      sample(65, 57); chk("inverted_y", 32'(color), 32'h123);
      send(w_bg(12'h456));
      px = 0; py = 0; instr = CMT; rdy = 1'b1;
      step();
      rdy = 1'b0; instr = '0;
      chk("fs_commit_pending", 32'(pend), 32'h1);
      sample(300, 3); chk("fs_commit_deferred", 32'(color), 32'h123);
      frame();
      sample(300, 3); chk("fs_commit_next_frame", 32'(color), 32'h456);
      send(w_bg(12'hABC)); send(CMT);
      sample(123, 45); chk("pre_reset_color", 32'(color), 32'h456);
      rst_n = 1'b0;
      step();
      chk("midframe_reset_pending", 32'(pend), 32'h0);
      chk("midframe_reset_color", 32'(color), 32'h000);
      rst_n = 1'b1;
      frame();
      sample(15, 15); chk("reset_discards_commit", 32'(color), 32'h000);
      chk("reset_no_pending", 32'(pend), 32'h0);
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
